vect_loader: RTL

VECT_LOADER -- requirements
Module: vect_loader

---
 rtl/vect_pkg.sv | 16 +
 rtl/vect_loader_if.sv | 32 +++
 rtl/vect_loader.sv | 95 +++++++++
 3 files changed

// File: rtl/vect_pkg.sv
// Shared widths, vector length and FSM state type for the vector loader.
package vect_pkg;

   localparam int unsigned FEATURE_WIDTH_DEF  = 5;
   localparam int unsigned WEIGHT_WIDTH_DEF   = 5;
   localparam int unsigned DOT_PROD_WIDTH_DEF = 16;
   localparam int unsigned VEC_LEN_DEF        = 96;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FILL    = 2'd1,
      CAPTURE = 2'd2,
      OUT     = 2'd3
   } state_e;

endpackage

// File: rtl/vect_loader_if.sv
// Element-pair stream, vector buffers, external multiplier link and result handshake.
interface vect_loader_if #(
   parameter int unsigned FEATURE_WIDTH  = vect_pkg::FEATURE_WIDTH_DEF,
   parameter int unsigned WEIGHT_WIDTH   = vect_pkg::WEIGHT_WIDTH_DEF,
   parameter int unsigned DOT_PROD_WIDTH = vect_pkg::DOT_PROD_WIDTH_DEF,
   parameter int unsigned VEC_LEN        = vect_pkg::VEC_LEN_DEF
) ();

   logic                      IN_VALID;
   logic                      IN_READY;
   logic [FEATURE_WIDTH-1:0]  IN_FEATURE;
   logic [WEIGHT_WIDTH-1:0]   IN_WEIGHT;
   logic                      IN_LAST;
   logic [FEATURE_WIDTH-1:0]  FEATURE_COL [VEC_LEN];
   logic [WEIGHT_WIDTH-1:0]   WEIGHT_ROW  [VEC_LEN];
   logic [DOT_PROD_WIDTH-1:0] PRODUCT;
   logic                      RES_VALID;
   logic                      RES_READY;
   logic [DOT_PROD_WIDTH-1:0] RES_DATA;
   logic                      ERR_LEN;

   modport slave (
      input  IN_VALID, IN_FEATURE, IN_WEIGHT, IN_LAST, PRODUCT, RES_READY,
      output IN_READY, FEATURE_COL, WEIGHT_ROW, RES_VALID, RES_DATA, ERR_LEN
   );

   modport master (
      output IN_VALID, IN_FEATURE, IN_WEIGHT, IN_LAST, PRODUCT, RES_READY,
      input  IN_READY, FEATURE_COL, WEIGHT_ROW, RES_VALID, RES_DATA, ERR_LEN
   );

endinterface

// File: rtl/vect_loader.sv
// Loads feature/weight element pairs into vector buffers, captures the external
// dot product and presents it on a valid/ready result port.
module vect_loader
   import vect_pkg::*;
#(
   parameter int unsigned FEATURE_WIDTH  = FEATURE_WIDTH_DEF,
   parameter int unsigned WEIGHT_WIDTH   = WEIGHT_WIDTH_DEF,
   parameter int unsigned DOT_PROD_WIDTH = DOT_PROD_WIDTH_DEF,
   parameter int unsigned VEC_LEN        = VEC_LEN_DEF
) (
   input  logic        CLK,
   input  logic        RST_N,
   vect_loader_if.slave bus
);

   localparam int unsigned          IDX_W    = $clog2(VEC_LEN);
   localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(VEC_LEN - 1);

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [FEATURE_WIDTH-1:0]  feat_q [VEC_LEN];
   logic [FEATURE_WIDTH-1:0]  feat_d [VEC_LEN];
   logic [WEIGHT_WIDTH-1:0]   wgt_q  [VEC_LEN];
   logic [WEIGHT_WIDTH-1:0]   wgt_d  [VEC_LEN];
   logic [DOT_PROD_WIDTH-1:0] res_q, res_d;
   logic                      err_q, err_d;
   logic                      accept;
   logic                      at_last_slot;

   assign accept       = (state_q == FILL) && bus.IN_VALID;
   assign at_last_slot = (idx_q == LAST_IDX);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      feat_d  = feat_q;
      wgt_d   = wgt_q;
      res_d   = res_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: state_d = FILL;
         FILL: begin
            if (accept) begin
               feat_d[idx_q] = bus.IN_FEATURE;
               wgt_d[idx_q]  = bus.IN_WEIGHT;
               idx_d         = idx_q + 1'b1;
               if (bus.IN_LAST || at_last_slot) begin
                  state_d = CAPTURE;
                  // Length is correct only when IN_LAST lands exactly on the final slot.
                  err_d   = bus.IN_LAST ^ at_last_slot;
               end
            end
         end
         CAPTURE: begin
            res_d   = bus.PRODUCT;
            state_d = OUT;
         end
         OUT: begin
            if (bus.RES_READY) begin
               feat_d  = '{default: '0};
               wgt_d   = '{default: '0};
               idx_d   = '0;
               state_d = FILL;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         idx_q   <= '0;
         feat_q  <= '{default: '0};
         wgt_q   <= '{default: '0};
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         feat_q  <= feat_d;
         wgt_q   <= wgt_d;
         res_q   <= res_d;
         err_q   <= err_d;
      end
   end

   assign bus.IN_READY    = (state_q == FILL);
   assign bus.RES_VALID   = (state_q == OUT);
   assign bus.RES_DATA    = res_q;
   assign bus.ERR_LEN     = err_q;
   assign bus.FEATURE_COL = feat_q;
   assign bus.WEIGHT_ROW  = wgt_q;

endmodule
